// File: rtl/light_hash_param.sv
`default_nettype none
// ============================================================================
// Module   : light_hash_param
// Brief    : Framed byte-stream hash; ROUNDS AES S-box rounds per data byte
//            over a DIGEST_BYTES-wide state. Macro LH_LEN_PAD_EN adds a
//            length-pad pass between TAIL and the digest.
// Revision : 1.0
// ============================================================================
module light_hash_param #(
    parameter int         DIGEST_BYTES = 8,
    parameter int         ROUNDS       = 1,
    parameter int         MAX_LEN      = 32,
    parameter logic [7:0] HEAD_BYTE    = 8'hFF,
    parameter logic [7:0] TAIL_BYTE    = 8'h00
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                message_byte,
    input  logic                      message_valid,
    output logic                      message_ready,
    output logic [8*DIGEST_BYTES-1:0] digest,
    output logic                      digest_ready,
    output logic                      err_invalid_message_byte,
    output logic                      err_overflow
);

    localparam int c_len_w = $clog2(MAX_LEN + 1);
    localparam int c_rnd_w = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

    localparam logic [0:255][7:0] c_sbox = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ABSORB = 3'd1,
        S_ROUND  = 3'd2,
        S_PAD    = 3'd3,
        S_FINAL  = 3'd4
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [0:DIGEST_BYTES-1][7:0]    r_h;
    logic [0:DIGEST_BYTES-1][7:0]    w_round;
    logic [0:DIGEST_BYTES-1][7:0]    r_digest;
    logic [c_len_w-1:0]              r_len;
    logic [c_rnd_w-1:0]              r_rnd;
    logic [7:0]                      r_b;
    logic [7:0]                      w_len_byte;
    logic                            r_digest_ready;
    logic                            r_err_inv;
    logic                            r_err_ovf;

    logic w_accept, w_is_head, w_is_tail, w_is_data, w_last_rnd;
    logic w_clr_h, w_clr_len, w_load_b, w_pad_load, w_round_en;
    logic w_rnd_inc, w_len_inc, w_final, w_err_inv, w_err_ovf;

    // Ready is forced low while reset is held, even though the state is IDLE.
    assign message_ready = rst_n && ((r_state == S_IDLE) || (r_state == S_ABSORB));
    assign w_accept      = message_valid && message_ready;
    assign w_is_head     = (message_byte == HEAD_BYTE);
    assign w_is_tail     = (message_byte == TAIL_BYTE);
    assign w_is_data     = ((message_byte >= 8'h20) && (message_byte <= 8'h7E)) ||
                           (message_byte >= 8'hA1);
    assign w_last_rnd    = (r_rnd == c_rnd_w'(ROUNDS - 1));
    assign w_len_byte    = 8'(r_len);

    assign digest                   = r_digest;
    assign digest_ready             = r_digest_ready;
    assign err_invalid_message_byte = r_err_inv;
    assign err_overflow             = r_err_ovf;

    for (genvar j = 0; j < DIGEST_BYTES; j++) begin : g_round
        localparam int c_src = (j + 2) % DIGEST_BYTES;
        localparam int c_rot = j % 8;
        logic [7:0]  w_t;
        logic [15:0] w_tt;
        assign w_t        = r_h[c_src] ^ r_b;
        assign w_tt       = {w_t, w_t};
        assign w_round[j] = c_sbox[w_tt[15-c_rot -: 8]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clr_h     = 1'b0;
        w_clr_len   = 1'b0;
        w_load_b    = 1'b0;
        w_pad_load  = 1'b0;
        w_round_en  = 1'b0;
        w_rnd_inc   = 1'b0;
        w_len_inc   = 1'b0;
        w_final     = 1'b0;
        w_err_inv   = 1'b0;
        w_err_ovf   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_head) begin
                    w_clr_h     = 1'b1;
                    w_clr_len   = 1'b1;
                    w_state_nxt = S_ABSORB;
                end
            end
            S_ABSORB: begin
                if (w_accept) begin
                    // Marker checks come first: HEAD/TAIL may fall inside the data ranges.
                    if (w_is_head) begin
                        w_clr_h   = 1'b1;
                        w_clr_len = 1'b1;
                    end else if (w_is_tail) begin
`ifdef LH_LEN_PAD_EN
                        w_pad_load  = 1'b1;
                        w_state_nxt = S_PAD;
`else
                        w_state_nxt = S_FINAL;
`endif
                    end else if (w_is_data) begin
                        if (r_len == c_len_w'(MAX_LEN)) begin
                            w_err_ovf   = 1'b1;
                            w_clr_h     = 1'b1;
                            w_clr_len   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_load_b    = 1'b1;
                            w_state_nxt = S_ROUND;
                        end
                    end else begin
                        w_err_inv   = 1'b1;
                        w_clr_h     = 1'b1;
                        w_clr_len   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_ROUND: begin
                w_round_en = 1'b1;
                if (w_last_rnd) begin
                    w_len_inc   = 1'b1;
                    w_state_nxt = S_ABSORB;
                end else begin
                    w_rnd_inc = 1'b1;
                end
            end
            S_PAD: begin
                w_round_en = 1'b1;
                if (w_last_rnd) begin
                    w_state_nxt = S_FINAL;
                end else begin
                    w_rnd_inc = 1'b1;
                end
            end
            S_FINAL: begin
                w_final     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h            <= '0;
            r_len          <= '0;
            r_rnd          <= '0;
            r_b            <= '0;
            r_digest       <= '0;
            r_digest_ready <= 1'b0;
            r_err_inv      <= 1'b0;
            r_err_ovf      <= 1'b0;
        end else begin
            r_digest_ready <= w_final;
            r_err_inv      <= w_err_inv;
            r_err_ovf      <= w_err_ovf;
            if (w_clr_h) begin
                r_h <= '0;
            end else if (w_round_en) begin
                r_h <= w_round;
            end
            if (w_clr_len) begin
                r_len <= '0;
            end else if (w_len_inc) begin
                r_len <= r_len + 1'b1;
            end
            if (w_load_b) begin
                r_b   <= message_byte;
                r_rnd <= '0;
            end else if (w_pad_load) begin
                r_b   <= w_len_byte;
                r_rnd <= '0;
            end else if (w_rnd_inc) begin
                r_rnd <= r_rnd + 1'b1;
            end
            if (w_final) begin
                r_digest <= r_h;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_light_hash_param.sv
`default_nettype none
// tb_light_hash_param: two configurations driven with directed and random frames,
// scored against a byte-level model whose S-box is derived from GF(2^8) arithmetic.
module tb_light_hash_param;

    localparam logic [7:0] HEAD   = 8'hFF;
    localparam logic [7:0] TAIL   = 8'h00;
    localparam logic [2:0] EV_DIG = 3'b100;
    localparam logic [2:0] EV_INV = 3'b010;
    localparam logic [2:0] EV_OVF = 3'b001;

    typedef struct packed {
        logic [2:0]   kind;
        logic [255:0] val;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    logic [7:0] sbox_tb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    function automatic logic is_legal(input logic [7:0] b);
        return (b inside {[8'h20:8'h7E], [8'hA1:8'hFF]}) && (b != HEAD) && (b != TAIL);
    endfunction

    function automatic logic [7:0] rand_legal();
        logic [7:0] b;
        do b = 8'($urandom); while (!is_legal(b));
        return b;
    endfunction

    // S-box = affine transform of the multiplicative inverse in GF(2^8).
    initial begin : build_sbox
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_tb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    task automatic chk(input string name, input int ch, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL ch%0d %s: got %0h, required %0h", ch, name, act, exp);
        end
    endtask

    for (genvar c = 0; c < 2; c++) begin : g_ch
        localparam int CH = c;
        localparam int N  = (c == 0) ? 8 : 5;
        localparam int R  = (c == 0) ? 1 : 3;
        localparam int ML = (c == 0) ? 32 : 4;

        logic           rst_n;
        logic [7:0]     mbyte;
        logic           mvalid;
        logic           mready;
        logic [8*N-1:0] dig;
        logic           dr, ei, eo;

        light_hash_param #(
            .DIGEST_BYTES(N), .ROUNDS(R), .MAX_LEN(ML), .HEAD_BYTE(HEAD), .TAIL_BYTE(TAIL)
        ) u_dut (
            .clk                      (clk),
            .rst_n                    (rst_n),
            .message_byte             (mbyte),
            .message_valid            (mvalid),
            .message_ready            (mready),
            .digest                   (dig),
            .digest_ready             (dr),
            .err_invalid_message_byte (ei),
            .err_overflow             (eo)
        );

        ev_t          q [$];
        ev_t          mon_e;
        logic [7:0]   m_h [32];
        int           m_len;
        logic         m_in;
        logic [255:0] m_dig;

        task automatic m_clear();
            for (int j = 0; j < 32; j++) m_h[j] = 8'h00;
            m_len = 0;
        endtask

        task automatic m_round(input logic [7:0] b);
            logic [7:0] nh [32];
            for (int j = 0; j < N; j++)
                nh[j] = sbox_tb[rotl8(m_h[(j + 2) % N] ^ b, j % 8)];
            for (int j = 0; j < N; j++) m_h[j] = nh[j];
        endtask

        function automatic logic [255:0] m_pack();
            logic [255:0] v;
            v = '0;
            for (int j = 0; j < N; j++) v = (v << 8) | 256'(m_h[j]);
            return v;
        endfunction

        task automatic push_ev(input logic [2:0] kind, input logic [255:0] val);
            ev_t e;
            e.kind = kind;
            e.val  = val;
            q.push_back(e);
        endtask

        // Applies one accepted byte; returns the number of cycles ready should stay low.
        task automatic m_byte(input logic [7:0] b, output int busy);
            busy = 0;
            if (!m_in) begin
                if (b == HEAD) begin
                    m_clear();
                    m_in = 1'b1;
                end
            end else if (b == HEAD) begin
                m_clear();
            end else if (b == TAIL) begin
`ifdef LH_LEN_PAD_EN
                for (int r = 0; r < R; r++) m_round(8'(m_len));
                busy = R + 1;
`else
                busy = 1;
`endif
                m_dig = m_pack();
                push_ev(EV_DIG, m_dig);
                m_in = 1'b0;
            end else if (is_legal(b)) begin
                if (m_len == ML) begin
                    m_clear();
                    m_in = 1'b0;
                    push_ev(EV_OVF, m_dig);
                end else begin
                    for (int r = 0; r < R; r++) m_round(b);
                    m_len++;
                    busy = R;
                end
            end else begin
                m_clear();
                m_in = 1'b0;
                push_ev(EV_INV, m_dig);
            end
        endtask

        task automatic send(input logic [7:0] b);
            int waits, busy, exp_busy;
            mbyte  = b;
            mvalid = 1'b1;
            waits  = 0;
            while (!mready && waits < 64) begin
                @(negedge clk);
                waits++;
            end
            if (!mready) begin
                checks++;
                errors++;
                $display("FAIL ch%0d handshake_timeout: message_ready=0, required 1", CH);
                $fatal(1, "handshake timeout");
            end
            @(posedge clk);
            m_byte(b, exp_busy);
            @(negedge clk);
            mvalid = 1'b0;
            busy   = 0;
            while (!mready && busy < 64) begin
                busy++;
                @(negedge clk);
            end
            chk($sformatf("ready_low_cycles(byte %0h)", b), CH, 256'(busy), 256'(exp_busy));
        endtask

        task automatic check_reset(input string tag);
            chk({tag, "_ready"}, CH, 256'(mready), 256'(0));
            chk({tag, "_digest"}, CH, 256'(dig), 256'(0));
            chk({tag, "_pulses"}, CH, 256'({dr, ei, eo}), 256'(0));
        endtask

        always @(negedge clk) begin
            if (dr || ei || eo) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ch%0d unexpected_pulse: got dr/ei/eo=%b digest=%0h, required no pulse",
                             CH, {dr, ei, eo}, dig);
                end else begin
                    mon_e = q.pop_front();
                    chk("pulse_kind", CH, 256'({dr, ei, eo}), 256'(mon_e.kind));
                    chk("digest", CH, 256'(dig), mon_e.val);
                end
            end
        end

        initial begin : drv
            int n;
            rst_n  = 1'b0;
            mvalid = 1'b0;
            mbyte  = 8'h00;
            m_in   = 1'b0;
            m_dig  = '0;
            m_clear();
            repeat (3) @(negedge clk);
            check_reset("reset");
            rst_n = 1'b1;
            @(negedge clk);
            chk("ready_after_reset", CH, 256'(mready), 256'(1));

            send(HEAD); send(8'h20); send(TAIL);
            send(HEAD); send(TAIL);
            send(HEAD); send(8'h41); send(8'h07);
            send(8'h41); send(TAIL);
            send(HEAD); send(8'h41); send(8'h42); send(TAIL);
            send(HEAD);
            for (int i = 0; i <= ML; i++) send(rand_legal());
            send(HEAD); send(8'h20); send(HEAD); send(8'h20); send(TAIL);

            for (int f = 0; f < 10; f++) begin
                if ($urandom_range(0, 1) == 1) send(8'($urandom_range(1, 254)));
                send(HEAD);
                n = $urandom_range(0, ML);
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
                    if ($urandom_range(0, 15) == 0) send(8'($urandom));
                    else send(rand_legal());
                end
                send(TAIL);
            end

            send(HEAD); send(8'h66); send(TAIL);
            send(HEAD);
            mbyte  = 8'h20;
            mvalid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (R > 1) @(negedge clk);
            rst_n  = 1'b0;
            mvalid = 1'b0;
            #1;
            check_reset("reset_mid_round");
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            m_in  = 1'b0;
            m_dig = '0;
            m_clear();
            repeat (5) @(negedge clk);

            send(HEAD); send(8'h20); send(TAIL);
            repeat (20) @(negedge clk);
            chk("queue_drained", CH, 256'(q.size()), 256'(0));
            done_cnt++;
        end
    end

    initial begin : main
        wait (done_cnt == 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
